// File: rtl/analog_pos_if.sv
// Frame-rate position bus between the input front end and analog_pos_accum.
// master drives strobe/stick/buttons, slave returns positions and the moving flag.
interface analog_pos_if;
  // strobe is a level; the consumer acts once per 0->1 transition. Stick and
  // button values only need to be stable in the cycle where strobe first reads 1.
  logic       strobe;
  logic [7:0] ax;
  logic [7:0] ay;
  logic       left;
  logic       right;
  logic       up;
  logic       down;
  logic       invert_y;
  logic [7:0] pos_x;
  logic [7:0] pos_y;
  logic       moving;

  modport master (
    output strobe, ax, ay, left, right, up, down, invert_y,
    input  pos_x, pos_y, moving
  );

  modport slave (
    input  strobe, ax, ay, left, right, up, down, invert_y,
    output pos_x, pos_y, moving
  );
endinterface

// File: rtl/analog_pos_accum.sv
// Per-frame analog/digital position accumulator producing wrapping 8-bit X/Y bytes.
// Define ANALOG_POS_SAT_EN to saturate the accumulators instead of wrapping.
module analog_pos_accum #(
  parameter int DIG_RATE  = 10,
  parameter int DEADZONE  = 8,
  parameter int FRAC_BITS = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  analog_pos_if.slave  bus
);
  localparam int AW = 8 + FRAC_BITS;
  localparam int DW = AW + 1;

  localparam logic [AW-1:0]        ACC_RST  = AW'(128) << FRAC_BITS;
  localparam logic signed [DW-1:0] DIG_STEP = DW'(DIG_RATE) << FRAC_BITS;
  localparam logic [7:0]           DZ       = 8'(DEADZONE);

  logic [AW-1:0]        acc_x_q, acc_x_d;
  logic [AW-1:0]        acc_y_q, acc_y_d;
  logic                 strobe_q, strobe_d;
  logic                 moving_q, moving_d;
  logic                 upd;
  logic signed [DW-1:0] dx, dy_raw, dy;

  // -128 is pulled to -127 first so magnitude and negation never overflow.
  function automatic logic signed [DW-1:0] axis_delta(input logic [7:0] a,
                                                      input logic neg,
                                                      input logic pos);
    logic [7:0]           a_c;
    logic [7:0]           mag;
    logic signed [DW-1:0] d;
    a_c = (a == 8'h80) ? 8'h81 : a;
    mag = a_c[7] ? (8'd0 - a_c) : a_c;
    d   = '0;
    if (mag > DZ)
      d = DW'($signed(a_c));
    else if (pos && !neg)
      d = DIG_STEP;
    else if (neg && !pos)
      d = -DIG_STEP;
    return d;
  endfunction

  function automatic logic [AW-1:0] next_acc(input logic [AW-1:0]        acc,
                                             input logic signed [DW-1:0] d);
    logic [AW-1:0] res;
`ifdef ANALOG_POS_SAT_EN
    logic signed [AW+1:0] sum;
    sum = $signed({2'b00, acc}) + (AW+2)'(d);
    if (sum[AW+1])
      res = '0;
    else if (sum[AW])
      res = '1;
    else
      res = sum[AW-1:0];
`else
    res = acc + d[AW-1:0];
`endif
    return res;
  endfunction

  always_comb begin
    upd      = bus.strobe & ~strobe_q;
    dx       = axis_delta(bus.ax, bus.left, bus.right);
    dy_raw   = axis_delta(bus.ay, bus.up, bus.down);
    dy       = bus.invert_y ? -dy_raw : dy_raw;
    strobe_d = bus.strobe;
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    moving_d = moving_q;
    if (upd) begin
      acc_x_d  = next_acc(acc_x_q, dx);
      acc_y_d  = next_acc(acc_y_q, dy);
      moving_d = (dx != '0) || (dy != '0);
    end
  end

  // strobe_q resets high so a strobe already asserted at release is not an edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_x_q  <= ACC_RST;
      acc_y_q  <= ACC_RST;
      strobe_q <= 1'b1;
      moving_q <= 1'b0;
    end else begin
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      strobe_q <= strobe_d;
      moving_q <= moving_d;
    end
  end

  assign bus.pos_x  = acc_x_q[FRAC_BITS +: 8];
  assign bus.pos_y  = acc_y_q[FRAC_BITS +: 8];
  assign bus.moving = moving_q;
endmodule

// File: tb/tb_analog_pos_accum.sv
// Directed plus randomized frame sequences for analog_pos_accum, checked against
// an integer fixed-point position model (wrap or ANALOG_POS_SAT_EN saturation).
module tb_analog_pos_accum;
  localparam int DIG_RATE  = 10;
  localparam int DEADZONE  = 8;
  localparam int FRAC_BITS = 4;
  localparam int MOD       = 1 << (8 + FRAC_BITS);

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  int   m_acc_x;
  int   m_acc_y;
  bit   m_moving;

  analog_pos_if bus ();

  analog_pos_accum #(
    .DIG_RATE (DIG_RATE),
    .DEADZONE (DEADZONE),
    .FRAC_BITS(FRAC_BITS)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  function automatic int model_delta(input int a, input bit neg, input bit pos);
    int av;
    av = (a == -128) ? -127 : a;
    if ((av < 0 ? -av : av) > DEADZONE) return av;
    if (pos && !neg) return DIG_RATE * (1 << FRAC_BITS);
    if (neg && !pos) return -DIG_RATE * (1 << FRAC_BITS);
    return 0;
  endfunction

  function automatic int fold(input int v);
`ifdef ANALOG_POS_SAT_EN
    if (v < 0) return 0;
    if (v > MOD - 1) return MOD - 1;
    return v;
`else
    return ((v % MOD) + MOD) % MOD;
`endif
  endfunction

  task automatic model_reset();
    m_acc_x  = 128 << FRAC_BITS;
    m_acc_y  = 128 << FRAC_BITS;
    m_moving = 1'b0;
  endtask

  task automatic model_update(input logic [7:0] ax, input logic [7:0] ay,
                              input bit l, input bit r, input bit u,
                              input bit d, input bit inv);
    int dx, dy;
    dx = model_delta(int'($signed(ax)), l, r);
    dy = model_delta(int'($signed(ay)), u, d);
    if (inv) dy = -dy;
    m_acc_x  = fold(m_acc_x + dx);
    m_acc_y  = fold(m_acc_y + dy);
    m_moving = (dx != 0) || (dy != 0);
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pos_x"}, bus.pos_x, 8'(m_acc_x >> FRAC_BITS));
    check({tag, "_pos_y"}, bus.pos_y, 8'(m_acc_y >> FRAC_BITS));
    check({tag, "_moving"}, {7'd0, bus.moving}, {7'd0, m_moving});
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    bus.ax       = 8'($urandom);
    bus.ay       = 8'($urandom);
    bus.left     = 1'($urandom);
    bus.right    = 1'($urandom);
    bus.up       = 1'($urandom);
    bus.down     = 1'($urandom);
    bus.invert_y = 1'($urandom);
  endtask

  task automatic do_reset(input logic strobe_lvl);
    reset_n    = 1'b0;
    bus.strobe = strobe_lvl;
    tick();
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic frame(input logic [7:0] ax, input logic [7:0] ay,
                       input bit l, input bit r, input bit u, input bit d,
                       input bit inv, input int low_n, input int high_n);
    for (int i = 0; i < low_n; i++) begin
      bus.strobe = 1'b0;
      junk();
      tick();
    end
    bus.strobe   = 1'b1;
    bus.ax       = ax;
    bus.ay       = ay;
    bus.left     = l;
    bus.right    = r;
    bus.up       = u;
    bus.down     = d;
    bus.invert_y = inv;
    tick();
    model_update(ax, ay, l, r, u, d, inv);
    for (int i = 1; i < high_n; i++) begin
      junk();
      tick();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    bus.strobe  = 1'b0;
    bus.ax = 8'h00; bus.ay = 8'h00;
    bus.left = 1'b0; bus.right = 1'b0; bus.up = 1'b0; bus.down = 1'b0;
    bus.invert_y = 1'b0;
    model_reset();
    tick();

    // Reset with strobe high: no update until a fresh rising edge
    do_reset(1'b1);
    check("rst_pos_x", bus.pos_x, 8'h80);
    check("rst_pos_y", bus.pos_y, 8'h80);
    check("rst_moving", {7'd0, bus.moving}, 8'h00);
    bus.right = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("hold_after_rst_x", bus.pos_x, 8'h80);
    check_model("hold_after_rst");

    // Digital right, three frames, then release
    for (int i = 0; i < 3; i++) frame(8'h00, 8'h00, 0, 1, 0, 0, 0, 1, 1);
    check("right3_x", bus.pos_x, 8'h9E);
    check("right3_y", bus.pos_y, 8'h80);
    check("right3_moving", {7'd0, bus.moving}, 8'h01);
    check_model("right3");
    frame(8'h00, 8'h00, 0, 0, 0, 0, 0, 2, 1);
    check("release_moving", {7'd0, bus.moving}, 8'h00);
    check_model("release");

    // Analog step, deadzone versus digital
    do_reset(1'b0);
    frame(8'h40, 8'h00, 0, 0, 0, 0, 0, 1, 1);
    frame(8'h40, 8'h00, 0, 0, 0, 0, 0, 1, 1);
    check("analog40_x", bus.pos_x, 8'h88);
    frame(8'h05, 8'h00, 0, 1, 0, 0, 0, 1, 2);
    check("dz_digital_x", bus.pos_x, 8'h92);
    frame(8'h05, 8'h00, 0, 0, 0, 0, 0, 1, 1);
    check("dz_idle_x", bus.pos_x, 8'h92);
    check("dz_idle_moving", {7'd0, bus.moving}, 8'h00);
    check_model("deadzone");

    // Long strobe: exactly one step; opposing buttons cancel
    do_reset(1'b0);
    frame(8'h00, 8'h00, 1, 0, 0, 0, 0, 1, 100);
    check("long_strobe_x", bus.pos_x, 8'h76);
    check_model("long_strobe");
    frame(8'h00, 8'h00, 1, 1, 1, 1, 0, 1, 1);
    check("opposed_x", bus.pos_x, 8'h76);
    check("opposed_moving", {7'd0, bus.moving}, 8'h00);

    // Top boundary: wrap or saturate
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) frame(8'h00, 8'h00, 0, 1, 0, 0, 0, 1, 1);
    frame(8'h20, 8'h00, 0, 0, 0, 0, 0, 1, 1);
    check("edge_setup_x", bus.pos_x, 8'hFA);
    frame(8'h00, 8'h00, 0, 1, 0, 0, 0, 1, 1);
`ifdef ANALOG_POS_SAT_EN
    check("edge_step_x", bus.pos_x, 8'hFF);
`else
    check("edge_step_x", bus.pos_x, 8'h04);
`endif
    check_model("edge_step");

    // -128 on Y with invert: treated as +127
    do_reset(1'b0);
    frame(8'h00, 8'h80, 0, 0, 0, 0, 1, 1, 1);
    check("neg128_inv_y", bus.pos_y, 8'h87);
    check_model("neg128_inv");

    // Reset coincident with strobe rise discards the step
    do_reset(1'b0);
    bus.strobe = 1'b0;
    tick();
    bus.strobe = 1'b1;
    bus.down   = 1'b1;
    bus.up     = 1'b0;
    reset_n    = 1'b0;
    tick();
    reset_n = 1'b1;
    model_reset();
    tick();
    tick();
    check("rst_vs_upd_y", bus.pos_y, 8'h80);
    check("rst_vs_upd_moving", {7'd0, bus.moving}, 8'h00);
    frame(8'h00, 8'h00, 0, 0, 0, 1, 0, 1, 1);
    check("post_rst_down_y", bus.pos_y, 8'h8A);

    // Randomized frames with junk on inputs outside the update cycle
    do_reset(1'b0);
    for (int n = 0; n < 300; n++) begin
      logic [7:0] rax, ray;
      if ($urandom_range(0, 2) == 0) begin
        rax = 8'(int'($urandom_range(0, 20)) - 10);
        ray = 8'(int'($urandom_range(0, 20)) - 10);
      end else begin
        rax = 8'($urandom);
        ray = 8'($urandom);
      end
      frame(rax, ray, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
